// File: rtl/board_writer_pkg.sv
// board_writer_pkg: board geometry, writer state type and the shared cell-to-word address formula.
package board_writer_pkg;
  localparam int WORD_SIZE = 16;
  localparam int LOG_WORD_SIZE = 4;
  localparam int BOARD_SIZE = 64;
  localparam int LOG_BOARD_SIZE = 6;
  localparam int LOG_MAX_ADDR = 2 * LOG_BOARD_SIZE - LOG_WORD_SIZE;
  localparam int WORDS_PER_ROW = BOARD_SIZE / WORD_SIZE;

  typedef logic [LOG_BOARD_SIZE-1:0] pos_t;
  typedef logic [LOG_MAX_ADDR-1:0] addr_t;
  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_EDIT_RD,
    ST_EDIT_MOD
  } board_wstate_t;

  // Row-major word address; the render fetch uses this same function.
  function automatic addr_t cell_word_addr(input pos_t x, input pos_t y);
    return addr_t'({y, x[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]});
  endfunction
endpackage

// File: rtl/board_writer_cell_packer.sv
// cell_packer: shift register and x/y raster counters for the serial cell stream.
module cell_packer
  import board_writer_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_n_in,
  input  logic  clear_in,
  input  logic  shift_in,
  input  logic  cell_in,
  output pos_t  x_out,
  output pos_t  y_out,
  output word_t word_out,
  output logic  word_done_out,
  output logic  last_out
);
  pos_t x_q, x_d, y_q, y_d;
  word_t sh_q, sh_d;

  assign x_out = x_q;
  assign y_out = y_q;
  assign word_out = {sh_q[WORD_SIZE-2:0], cell_in};
  assign word_done_out = shift_in && (&x_q[LOG_WORD_SIZE-1:0]);
  assign last_out = shift_in && (&x_q) && (&y_q);

  always_comb begin
    x_d = clear_in ? '0 : shift_in ? x_q + pos_t'(1) : x_q;
    y_d = clear_in ? '0 : (shift_in && (&x_q)) ? y_q + pos_t'(1) : y_q;
    sh_d = clear_in ? '0 : shift_in ? word_out : sh_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      x_q <= '0;
      y_q <= '0;
      sh_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      sh_q <= sh_d;
    end
endmodule

// File: rtl/board_writer.sv
// board_writer: packs a serial cell stream into board memory words and toggles single cells
// by read-modify-write, using the same bit layout as the render fetch.
module board_writer
  import board_writer_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      start_in,
  input  logic                      cell_valid_in,
  input  logic                      cell_in,
  output logic                      cell_ready_out,
  input  logic                      edit_in,
  input  logic [LOG_BOARD_SIZE-1:0] edit_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] edit_y_in,
  input  logic [WORD_SIZE-1:0]      data_r_in,
  output logic [LOG_MAX_ADDR-1:0]   addr_r_out,
  output logic [LOG_MAX_ADDR-1:0]   addr_w_out,
  output logic [WORD_SIZE-1:0]      data_w_out,
  output logic                      we_out,
  output logic                      busy_out,
  output logic                      done_out
);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam word_t MSB = {1'b1, {(WORD_SIZE-1){1'b0}}};

  board_wstate_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LOG_WORD_SIZE-1:0] bit_q, bit_d;
  addr_t addr_r_q, addr_r_d, addr_w_q, addr_w_d;
  word_t data_w_q, data_w_d, word;
  logic we_q, we_d, done_q, done_d;
  logic idle, stream, clear, shift, word_done, last;
  pos_t px, py;

  assign idle = state_q == ST_IDLE;
  assign stream = state_q == ST_STREAM;
  assign clear = start_in && (idle || stream);
  assign shift = cell_valid_in && stream;

  assign cell_ready_out = stream;
  assign busy_out = !idle;
  assign addr_r_out = addr_r_q;
  assign addr_w_out = addr_w_q;
  assign data_w_out = data_w_q;
  assign we_out = we_q;
  assign done_out = done_q;

  cell_packer u_packer (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .clear_in      (clear),
    .shift_in      (shift),
    .cell_in       (cell_in),
    .x_out         (px),
    .y_out         (py),
    .word_out      (word),
    .word_done_out (word_done),
    .last_out      (last)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    addr_r_d = addr_r_q;
    addr_w_d = addr_w_q;
    data_w_d = data_w_q;
    we_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      ST_IDLE:
        if (start_in) state_d = ST_STREAM;
        else if (edit_in) begin
          state_d = (READ_LATENCY == 1) ? ST_EDIT_MOD : ST_EDIT_RD;
          cnt_d = '0;
          bit_d = edit_x_in[LOG_WORD_SIZE-1:0];
          addr_r_d = cell_word_addr(edit_x_in, edit_y_in);
        end
      ST_STREAM: begin
        if (word_done) begin
          we_d = 1'b1;
          data_w_d = word;
          addr_w_d = cell_word_addr(px, py);
        end
        // A restart on the final cell keeps streaming rather than finishing.
        if (last && !start_in) begin
          done_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EDIT_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(READ_LATENCY - 2)) state_d = ST_EDIT_MOD;
      end
      default: begin
        data_w_d = data_r_in ^ (MSB >> bit_q);
        addr_w_d = addr_r_q;
        we_d = 1'b1;
        done_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      addr_r_q <= '0;
      addr_w_q <= '0;
      data_w_q <= '0;
      we_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      addr_r_q <= addr_r_d;
      addr_w_q <= addr_w_d;
      data_w_q <= data_w_d;
      we_q <= we_d;
      done_q <= done_d;
    end
endmodule
